// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: store size encodings and formatted byte-lane types shared by MEM-stage store/load logic
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam int LANES = 4;
  localparam int LANE_W = 32 + LANES;
  typedef struct packed {
    logic [LANES-1:0] be;
    logic [31:0] data;
  } lane_t;
endpackage

// File: rtl/store_lane_fmt.sv
// store_lane_fmt: maps store size/low address bits to byte enables, replicated data and a misalignment flag
module store_lane_fmt
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output lane_t       lane,
  output logic        misaligned
);
  always_comb begin
    misaligned = (size == SZ_RSVD) || (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
    lane.be = size == SZ_BYTE ? 4'b0001 << addr_lo :
              size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane.data = size == SZ_BYTE ? {4{data[7:0]}} :
                size == SZ_HALF ? {2{data[15:0]}} : data;
  end
endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: posted-write FIFO for MEM-stage stores with word-address load hazard detection
module mem_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [1:0]                 st_size,
  input  logic [ADDR_W-1:0]          ld_check_addr,
  input  logic                       ld_check_valid,
  output logic                       ld_hazard,
  output logic                       mem_wr_valid,
  input  logic                       mem_wr_ready,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]          mem_wr_data,
  output logic [3:0]                 mem_wr_be,
  output logic                       misaligned_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0] vld;
  logic [ADDR_W-3:0] waddr_q [DEPTH];
  lane_t lane_q [DEPTH];
  lane_t fmt_lane;
  logic fmt_mis, push, pop, unused_ok;
  store_lane_fmt u_fmt (
    .addr_lo    (st_addr[1:0]),
    .size       (st_size),
    .data       (st_data),
    .lane       (fmt_lane),
    .misaligned (fmt_mis)
  );
  assign st_ready     = count != CW'(DEPTH);
  assign mem_wr_valid = count != '0;
  assign empty        = count == '0;
  assign push         = st_valid && st_ready && !fmt_mis;
  assign pop          = mem_wr_valid && mem_wr_ready;
  assign mem_wr_addr  = {waddr_q[rd_ptr], 2'b00};
  assign mem_wr_data  = lane_q[rd_ptr].data;
  assign mem_wr_be    = lane_q[rd_ptr].be;
  assign unused_ok    = ^ld_check_addr[1:0];
  // per-entry valid bits let the hazard compare skip stale slots without pointer arithmetic
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      ld_hazard = ld_hazard | (ld_check_valid && vld[i] && waddr_q[i] == ld_check_addr[ADDR_W-1:2]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      vld            <= '0;
      misaligned_err <= 1'b0;
    end else begin
      misaligned_err <= st_valid && st_ready && fmt_mis;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      vld <= (vld & ~(pop ? {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr : '0))
           | (push ? {{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr : '0);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr] <= st_addr[ADDR_W-1:2];
      lane_q[wr_ptr]  <= fmt_lane;
    end
  end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed stimulus with a queue-based reference model checked every cycle
module tb_mem_store_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1;
  logic st_valid = 0, st_ready;
  logic [31:0] st_addr = 0, st_data = 0;
  logic [1:0] st_size = 0;
  logic [31:0] ld_check_addr = 0;
  logic ld_check_valid = 0, ld_hazard;
  logic mem_wr_valid, mem_wr_ready = 0;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0] mem_wr_be;
  logic misaligned_err, empty;
  logic [2:0] count;
  int tests = 0, fails = 0;
  bit armed = 0;

  mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .ld_check_addr(ld_check_addr), .ld_check_valid(ld_check_valid), .ld_hazard(ld_hazard),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be), .misaligned_err(misaligned_err),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];
  bit exp_mis = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // lane-by-lane view of what a store writes into memory
  task automatic model_fmt(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                           output ent_t e, output bit bad);
    int lo;
    lo = int'(a[1:0]);
    bad = (sz == 3) || (sz == 1 && lo % 2 == 1) || (sz == 2 && lo != 0);
    e.addr = a & 32'hFFFF_FFFC;
    for (int l = 0; l < 4; l++) begin
      e.be[l] = sz == 0 ? (l == lo) : sz == 1 ? (l / 2 == lo / 2) : 1'b1;
      e.data[l*8 +: 8] = sz == 0 ? d[7:0] : sz == 1 ? d[(l%2)*8 +: 8] : d[l*8 +: 8];
    end
  endtask

  always @(posedge clk) begin
    ent_t e;
    bit bad, rdy, do_pop;
    if (reset) begin
      q.delete();
      exp_mis = 0;
    end else begin
      model_fmt(st_addr, st_size, st_data, e, bad);
      rdy = q.size() < DEPTH;
      do_pop = q.size() > 0 && mem_wr_ready;
      exp_mis = st_valid && rdy && bad;
      if (do_pop) void'(q.pop_front());
      if (st_valid && rdy && !bad) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    bit hz;
    if (armed) begin
      hz = 0;
      foreach (q[i]) if (q[i].addr[31:2] == ld_check_addr[31:2]) hz = 1;
      chk("st_ready", st_ready, q.size() < DEPTH);
      chk("mem_wr_valid", mem_wr_valid, q.size() > 0);
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("misaligned_err", misaligned_err, exp_mis);
      chk("ld_hazard", ld_hazard, ld_check_valid && hz);
      if (q.size() > 0) begin
        chk("mem_wr_addr", mem_wr_addr, q[0].addr);
        chk("mem_wr_data", mem_wr_data, q[0].data);
        chk("mem_wr_be", mem_wr_be, q[0].be);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1; st_size = sz; st_addr = a; st_data = d;
  endtask

  initial begin
    step(); step();
    reset = 0;
    armed = 1;
    @(negedge clk);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst st_ready", st_ready, 1);
    chk("rst valid", mem_wr_valid, 0);
    // sb into the top lane
    drive(2'b00, 32'h103, 32'hAB);
    step();
    st_valid = 0;
    @(negedge clk);
    chk("sb addr", mem_wr_addr, 32'h100);
    chk("sb be", mem_wr_be, 4'b1000);
    chk("sb data", mem_wr_data, 32'hABABABAB);
    chk("sb valid", mem_wr_valid, 1);
    mem_wr_ready = 1;
    step();
    // fill with ready low, then refused push while full
    mem_wr_ready = 0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b10, 32'h400 + 4 * k, 32'h1111_0000 + k);
      step();
    end
    st_valid = 0;
    @(negedge clk);
    chk("full st_ready", st_ready, 0);
    chk("full count", count, 4);
    drive(2'b10, 32'h500, 32'hDEAD);
    mem_wr_ready = 1;
    step();
    st_valid = 0;
    @(negedge clk);
    chk("full no passthru", count, 3);
    for (int k = 1; k < 4; k++) begin
      chk("drain order", mem_wr_data, 32'h1111_0000 + k);
      step();
      @(negedge clk);
    end
    chk("drain empty", empty, 1);
    // misaligned half
    drive(2'b01, 32'h201, 32'h5555);
    step();
    st_valid = 0;
    @(negedge clk);
    chk("mis pulse", misaligned_err, 1);
    chk("mis count", count, 0);
    chk("mis valid", mem_wr_valid, 0);
    step();
    @(negedge clk);
    chk("mis one cycle", misaligned_err, 0);
    drive(2'b11, 32'h800, 32'h1);
    step();
    st_valid = 0;
    @(negedge clk);
    chk("rsvd pulse", misaligned_err, 1);
    // upper half-word store
    mem_wr_ready = 0;
    drive(2'b01, 32'h702, 32'h1234_5678);
    step();
    st_valid = 0;
    @(negedge clk);
    chk("sh addr", mem_wr_addr, 32'h700);
    chk("sh be", mem_wr_be, 4'b1100);
    chk("sh data", mem_wr_data, 32'h5678_5678);
    mem_wr_ready = 1;
    step();
    // load hazard
    mem_wr_ready = 0;
    drive(2'b10, 32'h300, 32'hCAFE);
    step();
    st_valid = 0;
    ld_check_valid = 1;
    ld_check_addr = 32'h302;
    @(negedge clk);
    chk("hazard hit", ld_hazard, 1);
    #1 ld_check_addr = 32'h304;
    #1 chk("hazard miss", ld_hazard, 0);
    ld_check_addr = 32'h302;
    mem_wr_ready = 1;
    step();
    @(negedge clk);
    chk("hazard after pop", ld_hazard, 0);
    ld_check_valid = 0;
    // steady push+pop across pointer wrap
    mem_wr_ready = 0;
    drive(2'b10, 32'h600, 32'hD0D0);
    step();
    drive(2'b10, 32'h604, 32'hD1D1);
    step();
    mem_wr_ready = 1;
    for (int k = 0; k < 10; k++) begin
      drive(2'b10, 32'h608 + 4 * k, 32'hE000 + k);
      step();
      @(negedge clk);
      chk("steady count", count, 2);
    end
    st_valid = 0;
    step(); step();
    @(negedge clk);
    chk("steady empty", empty, 1);
    // reset with pending entries
    mem_wr_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 32'h900 + 4 * k, 32'hF000 + k);
      step();
    end
    st_valid = 0;
    @(negedge clk);
    chk("pre-reset count", count, 3);
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("reset count", count, 0);
    chk("reset valid", mem_wr_valid, 0);
    mem_wr_ready = 1;
    step(); step();
    @(negedge clk);
    chk("post-reset idle", mem_wr_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
